// File: rtl/master_select_ctrl_if.sv
// Signal bundle between the A/B master sequencer and its surroundings.
// The slave modport is the sequencer's view; the master modport drives heartbeats and requests.
interface master_select_ctrl_if;
  logic       io_a;
  logic       io_b;
  logic       force_swi;
  logic       com_swi;
  logic       switch;
  logic       mute;
  logic       reset_A;
  logic       reset_B;
  logic       fault;
  logic       reject;
  logic       busy;
  logic [7:0] swap_cnt;

  modport slave (
    input  io_a, io_b, force_swi, com_swi,
    output switch, mute, reset_A, reset_B, fault, reject, busy, swap_cnt
  );

  modport master (
    output io_a, io_b, force_swi, com_swi,
    input  switch, mute, reset_A, reset_B, fault, reject, busy, swap_cnt
  );
endinterface

// File: rtl/master_select_ctrl.sv
// A/B master-CPU selection sequencer: startup pick, heartbeat failover with a muted
// guard window, commanded/forced swaps, and a reset pulse to the CPU that failed.
module master_select_ctrl #(
  parameter int STARTUP = 1000,
  parameter int HOLDOFF = 5000,
  parameter int GUARD   = 16,
  parameter int RST_LEN = 50000,
  parameter int CW      = 20
) (
  input logic                clk,
  input logic                rst,
  master_select_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_SWAP    = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP - 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD - 1);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_LEN - 1);
  localparam logic [CW-1:0] HOLD_MAX     = CW'(HOLDOFF);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fail_q, fail_d;
  logic          reason_fail_q, reason_fail_d;
  logic          failed_b_q, failed_b_d;
  logic          switch_q, switch_d;
  logic          mute_q, mute_d;
  logic          busy_q, busy_d;
  logic          reset_a_q, reset_a_d;
  logic          reset_b_q, reset_b_d;
  logic          fault_q, fault_d;
  logic          reject_q, reject_d;
  logic [7:0]    swap_cnt_q, swap_cnt_d;

  logic          active;
  logic          standby;
  logic          fail_hit;
  logic [CW-1:0] fail_next;
  logic          fault_next;

  always_comb begin
    active     = switch_q ? bus.io_b : bus.io_a;
    standby    = switch_q ? bus.io_a : bus.io_b;
    fail_hit   = (fail_q == HOLD_MAX);
    fail_next  = active ? '0 : (fail_hit ? HOLD_MAX : fail_q + CNT_ONE);
    // Fault latches at a declared failure with nobody to take over; any live heartbeat clears it.
    fault_next = (bus.io_a || bus.io_b) ? 1'b0 : ((fail_hit && !standby) ? 1'b1 : fault_q);
  end

  // NOTE: every next-state signal gets its hold/default value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fail_d        = fail_q;
    reason_fail_d = reason_fail_q;
    failed_b_d    = failed_b_q;
    switch_d      = switch_q;
    reset_a_d     = reset_a_q;
    reset_b_d     = reset_b_q;
    fault_d       = fault_q;
    reject_d      = 1'b0;
    swap_cnt_d    = swap_cnt_q;

    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == STARTUP_LAST) begin
          cnt_d    = '0;
          fail_d   = '0;
          switch_d = !bus.io_a && bus.io_b;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        fail_d  = fail_next;
        fault_d = fault_next;
        if (bus.force_swi) begin
          reason_fail_d = 1'b0;
          cnt_d         = '0;
          state_d       = S_SWAP;
        end else if (fail_hit && standby) begin
          reason_fail_d = 1'b1;
          failed_b_d    = switch_q;
          cnt_d         = '0;
          state_d       = S_SWAP;
        end else if (bus.com_swi) begin
          if (standby) begin
            reason_fail_d = 1'b0;
            cnt_d         = '0;
            state_d       = S_SWAP;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_SWAP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == GUARD_LAST) begin
          cnt_d      = '0;
          fail_d     = '0;
          switch_d   = !switch_q;
          swap_cnt_d = (swap_cnt_q == 8'hFF) ? swap_cnt_q : swap_cnt_q + 8'd1;
          if (reason_fail_q) begin
            reset_a_d = !failed_b_q;
            reset_b_d = failed_b_q;
            state_d   = S_RECOVER;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RECOVER: begin
        // Detection keeps running on the new master; any swap it calls for waits for RUN.
        fail_d  = fail_next;
        fault_d = fault_next;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == RST_LAST) begin
          cnt_d     = '0;
          reset_a_d = 1'b0;
          reset_b_d = 1'b0;
          state_d   = S_RUN;
        end
      end

      default: state_d = S_INIT;
    endcase

    mute_d = (state_d == S_INIT) || (state_d == S_SWAP);
    busy_d = (state_d != S_RUN);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      fail_q        <= '0;
      reason_fail_q <= 1'b0;
      failed_b_q    <= 1'b0;
      switch_q      <= 1'b0;
      mute_q        <= 1'b1;
      busy_q        <= 1'b1;
      reset_a_q     <= 1'b0;
      reset_b_q     <= 1'b0;
      fault_q       <= 1'b0;
      reject_q      <= 1'b0;
      swap_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fail_q        <= fail_d;
      reason_fail_q <= reason_fail_d;
      failed_b_q    <= failed_b_d;
      switch_q      <= switch_d;
      mute_q        <= mute_d;
      busy_q        <= busy_d;
      reset_a_q     <= reset_a_d;
      reset_b_q     <= reset_b_d;
      fault_q       <= fault_d;
      reject_q      <= reject_d;
      swap_cnt_q    <= swap_cnt_d;
    end
  end

  assign bus.switch   = switch_q;
  assign bus.mute     = mute_q;
  assign bus.busy     = busy_q;
  assign bus.reset_A  = reset_a_q;
  assign bus.reset_B  = reset_b_q;
  assign bus.fault    = fault_q;
  assign bus.reject   = reject_q;
  assign bus.swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_master_select_ctrl.sv
// Vector-table bench for master_select_ctrl: each row holds inputs for N cycles and the
// outputs expected after every one of those edges; expectations go through a scoreboard queue.
module tb_master_select_ctrl;
  localparam int STARTUP = 10;
  localparam int HOLDOFF = 8;
  localparam int GUARD   = 4;
  localparam int RST_LEN = 16;
  localparam int CW      = 20;

  logic clk = 1'b0;
  logic rst;

  master_select_ctrl_if bus ();

  master_select_ctrl #(
    .STARTUP(STARTUP), .HOLDOFF(HOLDOFF), .GUARD(GUARD), .RST_LEN(RST_LEN), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sw;
    logic       mute;
    logic       busy;
    logic       ra;
    logic       rb;
    logic       fault;
    logic       rej;
    logic [7:0] cnt;
  } outs_t;

  typedef struct {
    string name;
    logic  r, a, b, f, c;
    int    reps;
    outs_t exp;
  } vec_t;

  typedef struct {
    string name;
    outs_t exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic outs_t mk(logic sw, mute, busy, ra, rb, fault, rej, logic [7:0] cnt);
    outs_t o;
    o.sw = sw; o.mute = mute; o.busy = busy; o.ra = ra; o.rb = rb;
    o.fault = fault; o.rej = rej; o.cnt = cnt;
    return o;
  endfunction

  function automatic void add(string name, logic r, a, b, f, c, int reps, outs_t exp);
    vec_t v;
    v.name = name; v.r = r; v.a = a; v.b = b; v.f = f; v.c = c; v.reps = reps; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check_out();
    sb_t   e;
    outs_t act;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    act = mk(bus.switch, bus.mute, bus.busy, bus.reset_A, bus.reset_B,
             bus.fault, bus.reject, bus.swap_cnt);
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s @%0t: got sw=%b mute=%b busy=%b rA=%b rB=%b fault=%b rej=%b cnt=%0d, want sw=%b mute=%b busy=%b rA=%b rB=%b fault=%b rej=%b cnt=%0d",
               e.name, $time, act.sw, act.mute, act.busy, act.ra, act.rb, act.fault, act.rej, act.cnt,
               e.exp.sw, e.exp.mute, e.exp.busy, e.exp.ra, e.exp.rb, e.exp.fault, e.exp.rej, e.exp.cnt);
    end
  endtask

  task automatic step(string name, logic r, a, b, f, c, outs_t exp);
    sb_t e;
    rst = r; bus.io_a = a; bus.io_b = b; bus.force_swi = f; bus.com_swi = c;
    e.name = name; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1;
    bus.io_a = 1'b0; bus.io_b = 1'b1; bus.force_swi = 1'b0; bus.com_swi = 1'b0;

    //   name            rst a  b  f  c  reps  sw mu bu rA rB fl rj cnt
    add("reset",         1, 0, 1, 0, 0, 2,  mk(0, 1, 1, 0, 0, 0, 0, 0));
    add("init_wait",     0, 0, 1, 0, 0, 9,  mk(0, 1, 1, 0, 0, 0, 0, 0));
    add("startup_sel_b", 0, 0, 1, 0, 0, 1,  mk(1, 0, 0, 0, 0, 0, 0, 0));
    add("com_reject_a",  0, 0, 1, 0, 1, 1,  mk(1, 0, 0, 0, 0, 0, 1, 0));
    add("reject_drop",   0, 0, 1, 0, 0, 1,  mk(1, 0, 0, 0, 0, 0, 0, 0));
    add("a_alive",       0, 1, 1, 0, 0, 2,  mk(1, 0, 0, 0, 0, 0, 0, 0));
    add("force_to_a",    0, 1, 1, 1, 0, 1,  mk(1, 1, 1, 0, 0, 0, 0, 0));
    add("guard_to_a",    0, 1, 1, 0, 0, 3,  mk(1, 1, 1, 0, 0, 0, 0, 0));
    add("force_done_a",  0, 1, 1, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0, 1));
    add("b_dead_idle",   0, 1, 0, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0, 1));
    add("com_reject_b",  0, 1, 0, 0, 1, 1,  mk(0, 0, 0, 0, 0, 0, 1, 1));
    add("reject_drop_b", 0, 1, 0, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0, 1));
    add("force_b_dead",  0, 1, 0, 1, 0, 1,  mk(0, 1, 1, 0, 0, 0, 0, 1));
    add("guard_b_dead",  0, 1, 0, 0, 0, 3,  mk(0, 1, 1, 0, 0, 0, 0, 1));
    add("force_no_rst",  0, 1, 1, 0, 0, 1,  mk(1, 0, 0, 0, 0, 0, 0, 2));
    add("force_back",    0, 1, 1, 1, 0, 1,  mk(1, 1, 1, 0, 0, 0, 0, 2));
    add("guard_back",    0, 1, 1, 0, 0, 3,  mk(1, 1, 1, 0, 0, 0, 0, 2));
    add("back_on_a",     0, 1, 1, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0, 3));
    add("glitch_lo1",    0, 0, 1, 0, 0, 7,  mk(0, 0, 0, 0, 0, 0, 0, 3));
    add("glitch_hi",     0, 1, 1, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0, 3));
    add("glitch_lo2",    0, 0, 1, 0, 0, 7,  mk(0, 0, 0, 0, 0, 0, 0, 3));
    add("glitch_end",    0, 1, 1, 0, 0, 2,  mk(0, 0, 0, 0, 0, 0, 0, 3));
    add("a_fail_wait",   0, 0, 1, 0, 0, 8,  mk(0, 0, 0, 0, 0, 0, 0, 3));
    add("a_fail_guard",  0, 0, 1, 0, 0, 4,  mk(0, 1, 1, 0, 0, 0, 0, 3));
    add("a_fail_swap",   0, 0, 1, 0, 0, 1,  mk(1, 0, 1, 1, 0, 0, 0, 4));
    add("recover_a",     0, 0, 1, 0, 0, 5,  mk(1, 0, 1, 1, 0, 0, 0, 4));
    add("recover_com",   0, 0, 1, 0, 1, 1,  mk(1, 0, 1, 1, 0, 0, 0, 4));
    add("recover_a2",    0, 0, 1, 0, 0, 9,  mk(1, 0, 1, 1, 0, 0, 0, 4));
    add("recover_end",   0, 0, 1, 0, 0, 1,  mk(1, 0, 0, 0, 0, 0, 0, 4));
    add("both_dead",     0, 0, 0, 0, 0, 8,  mk(1, 0, 0, 0, 0, 0, 0, 4));
    add("fault_set",     0, 0, 0, 0, 0, 3,  mk(1, 0, 0, 0, 0, 1, 0, 4));
    add("fault_clear",   0, 0, 1, 0, 0, 2,  mk(1, 0, 0, 0, 0, 0, 0, 4));
    add("b_fail_wait",   0, 1, 0, 0, 0, 8,  mk(1, 0, 0, 0, 0, 0, 0, 4));
    add("b_fail_guard",  0, 1, 0, 0, 0, 4,  mk(1, 1, 1, 0, 0, 0, 0, 4));
    add("b_fail_swap",   0, 1, 0, 0, 0, 1,  mk(0, 0, 1, 0, 1, 0, 0, 5));
    add("recover_b",     0, 1, 0, 0, 0, 15, mk(0, 0, 1, 0, 1, 0, 0, 5));
    add("recover_b_end", 0, 1, 0, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0, 5));
    add("a_fail2_wait",  0, 0, 1, 0, 0, 8,  mk(0, 0, 0, 0, 0, 0, 0, 5));
    add("a_fail2_guard", 0, 0, 1, 0, 0, 4,  mk(0, 1, 1, 0, 0, 0, 0, 5));
    add("a_fail2_swap",  0, 0, 1, 0, 0, 1,  mk(1, 0, 1, 1, 0, 0, 0, 6));
    add("recover_a3",    0, 0, 1, 0, 0, 4,  mk(1, 0, 1, 1, 0, 0, 0, 6));
    add("rst_in_recov",  1, 0, 1, 0, 0, 2,  mk(0, 1, 1, 0, 0, 0, 0, 0));
    add("init2_wait",    0, 1, 0, 0, 0, 4,  mk(0, 1, 1, 0, 0, 0, 0, 0));
    add("init2_com",     0, 1, 0, 0, 1, 1,  mk(0, 1, 1, 0, 0, 0, 0, 0));
    add("init2_force",   0, 1, 0, 1, 0, 1,  mk(0, 1, 1, 0, 0, 0, 0, 0));
    add("init2_wait2",   0, 1, 0, 0, 0, 3,  mk(0, 1, 1, 0, 0, 0, 0, 0));
    add("startup_sel_a", 0, 1, 0, 0, 0, 1,  mk(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].reps; k++)
        step(vecs[i].name, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].c, vecs[i].exp);
    end

    // Requests during the guard window are dropped: no reject, no second swap afterwards.
    step("hs_force",      0, 1, 0, 1, 0, mk(0, 1, 1, 0, 0, 0, 0, 0));
    step("hs_com_guard",  0, 1, 0, 0, 1, mk(0, 1, 1, 0, 0, 0, 0, 0));
    step("hs_force_grd",  0, 1, 0, 1, 0, mk(0, 1, 1, 0, 0, 0, 0, 0));
    step("hs_guard_end",  0, 1, 0, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 0));
    step("hs_swapped",    0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 1));
    step("hs_not_queued", 0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 1));
    step("hs_still_run",  0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/master_select_ctrl.md
# master_select_ctrl

Sequencer that owns the A/B master-CPU selection for the dual-core switch board. It watches the per-CPU heartbeat levels from the PWM pulse detectors, plus the forced and commanded switch requests from the command decoder. It decides which CPU drives the serial and `sw*` outputs, mutes traffic during a hand-over, and pulses the reset line of a CPU that lost its heartbeat. Its `switch` output feeds the core datapath mux, and its reset outputs replace direct command-driven resets.

## Interface
Parameters:
- `STARTUP`, 1000: cycles in INIT before the first selection.
- `HOLDOFF`, 5000: consecutive cycles of active heartbeat low that declare a failure.
- `GUARD`, 16: cycles that `mute` is held before `switch` toggles.
- `RST_LEN`, 50000: width of the reset pulse to a failed CPU, in cycles.
- `CW`, 20: width of the internal counters. It must hold max(STARTUP, HOLDOFF, GUARD, RST_LEN).

Ports:
- `clk` in 1: the single clock. Everything is sampled on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `io_a`, `io_b` in 1: heartbeat-alive levels. 1 means alive.
- `force_swi` in 1: one-cycle pulse requesting an unconditional swap.
- `com_swi` in 1: one-cycle pulse requesting a swap, granted only if the standby CPU is alive.
- `switch` out 1: selected master. 0 selects A, 1 selects B.
- `mute` out 1: 1 blocks TX/`sw*` updates in the core.
- `reset_A`, `reset_B` out 1: active-high CPU reset pulses.
- `fault` out 1: both heartbeats are dead.
- `reject` out 1: one-cycle pulse when a `com_swi` request is refused.
- `busy` out 1: 1 in any state except RUN.
- `swap_cnt` out 8: number of completed swaps, saturating.

## Operation
- State machine states are INIT, RUN, SWAP and RECOVER. Reset enters INIT.
- "Active" means `io_a` when `switch`=0 and `io_b` when `switch`=1. "Standby" is the other CPU.
- **INIT**
  - `mute`=1. Count STARTUP cycles.
  - On the final cycle, `switch` is set to 0 if `io_a`=1. Otherwise it is set to 1 if `io_b`=1. Otherwise it is set to 0.
  - The next state is RUN.
- **RUN**
  - `mute`=0.
  - The fail counter increments while active=0 and clears while active=1. It saturates at HOLDOFF.
  - Requests are evaluated each cycle with priority force_swi > failure > com_swi:
    - `force_swi`: go to SWAP with reason=manual, regardless of heartbeats.
    - Failure: fail counter == HOLDOFF and standby=1. Go to SWAP with reason=fail and record the failed CPU.
    - Fail counter == HOLDOFF and standby=0: stay in RUN with `fault`=1, no swap. `fault` clears on the first cycle either heartbeat is 1.
    - `com_swi` with standby=1: go to SWAP with reason=manual.
    - `com_swi` with standby=0: pulse `reject` for one cycle and stay in RUN.
- **SWAP**
  - `mute`=1 for GUARD cycles.
  - On exit, `switch` toggles and `swap_cnt` increments (saturating at 255). The fail counter clears.
  - The next state is RECOVER if reason=fail, else RUN.
- **RECOVER**
  - `mute`=0. The new master runs normally.
  - The reset output of the failed CPU is 1 for RST_LEN cycles. Then go to RUN.
  - Failure detection on the new active CPU runs during RECOVER. A swap back is deferred until RUN.
- `force_swi` and `com_swi` arriving in INIT, SWAP or RECOVER are ignored and not queued. They do not produce `reject`.
- `rst` asserted in any state:
  - next cycle, state INIT;
  - all counters 0;
  - reset outputs drop immediately (a reset pulse in progress is truncated).
- Reset values:
  - `switch`=0, `mute`=1, `busy`=1;
  - `reset_A`=0, `reset_B`=0;
  - `fault`=0, `reject`=0, `swap_cnt`=0.
- All outputs are registered.

## Timing
- A request sampled at edge N in RUN gives `mute`=1 and `busy`=1 from N+1.
- `mute` stays high for exactly GUARD cycles, N+1 .. N+GUARD.
- `switch` toggles at N+GUARD+1, the same edge `mute` falls.
- On the failure path:
  - the reset pulse covers N+GUARD+1 .. N+GUARD+RST_LEN;
  - RUN is re-entered at N+GUARD+RST_LEN+1.
- Failure latency: the heartbeat falls at edge M. The fail counter reaches HOLDOFF at M+HOLDOFF-1, and SWAP is entered at M+HOLDOFF.
- A heartbeat glitch high for 1 cycle clears the fail counter. There is no accumulation across glitches.
- `reject` rises one cycle after the `com_swi` sample.
- `reset_A` and `reset_B` are never both 1.

## Test plan
Parameters for all scenarios: STARTUP=10, HOLDOFF=8, GUARD=4, RST_LEN=16.

- **Startup selection:** `rst` high, then low with `io_a`=0 and `io_b`=1. Required: `mute`=1 for 10 cycles, then `switch`=1, `mute`=0, `busy`=0.
- **Failure swap:** in RUN with `switch`=0 and both alive, drop `io_a`. Required:
  - after 8 cycles, `mute`=1 for 4 cycles;
  - then `switch`=1 and `reset_A`=1 for 16 cycles;
  - `swap_cnt`=1 and `reset_B`=0 throughout.
- **Glitch immunity:** `io_a` low for 7 cycles, high for 1, low for 7. Required: no swap and `swap_cnt` unchanged.
- **Command handling:**
  - `com_swi` with `io_b`=0: `reject` pulses 1 cycle and `switch` is unchanged.
  - `force_swi` with `io_b`=0: swap after 4 guard cycles, with no reset pulse.
- **Both dead:** `io_a`=`io_b`=0 for 8 cycles. Required: `fault`=1, no swap. Raising `io_b` clears `fault` the next cycle.
- **Reset mid-recovery:** assert `rst` 5 cycles into RECOVER. Required: next cycle `reset_A`=0, `mute`=1, `busy`=1, `swap_cnt`=0, state INIT.
